// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake plus ALU operand/result bus between issue control and the ALU.
interface alu_issue_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic              InstValid;
    logic              InstReady;
    logic [2+2*AW:0]   Inst;
    logic [DW-1:0]     DatA;
    logic [DW-1:0]     DatB;
    logic [2:0]        ALUop;
    logic [DW-1:0]     Rslt;
    logic              Zero;
    logic              Par;
    logic              SCo;
    logic [2:0]        Flags;
    logic              Done;
    modport master (
        input  InstValid, Inst, Rslt, Zero, Par, SCo,
        output InstReady, DatA, DatB, ALUop, Flags, Done
    );
    modport slave (
        output InstValid, Inst, Rslt, Zero, Par, SCo,
        input  InstReady, DatA, DatB, ALUop, Flags, Done
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues register-register ops to a combinational ALU and writes results back.
module alu_issue_ctrl #(
    parameter  int DW   = 8,
    parameter  int NREG = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  InitWe,
    input  logic [AW-1:0]         InitAddr,
    input  logic [DW-1:0]         InitData,
    input  logic [AW-1:0]         RdAddr,
    output logic [DW-1:0]         RdData,
    alu_issue_ctrl_if.master      bus
);
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
    state_t            state_q, state_d;
    logic [DW-1:0]     rf_q [NREG];
    logic [DW-1:0]     data_q, datb_q, rslt_q;
    logic [2:0]        op_q, flh_q, flags_q;
    logic [AW-1:0]     rd_q;
    logic [2:0]        op_i;
    logic [AW-1:0]     rd_i, rs_i;
    logic [DW-1:0]     opa, opb, wd;
    logic [AW-1:0]     wa;
    logic              ready, done, accept, wb_we, we;
    assign op_i = bus.Inst[2+2*AW -: 3];
    assign rd_i = bus.Inst[2*AW-1 -: AW];
    assign rs_i = bus.Inst[AW-1:0];
    // Addresses with no backing register fall through to the zero default.
    always_comb begin
        RdData = '0;
        opa = '0;
        opb = '0;
        for (int i = 0; i < NREG; i++) begin
            RdData = (RdAddr == AW'(i)) ? rf_q[i] : RdData;
            opa = (rd_i == AW'(i)) ? rf_q[i] : opa;
            opb = (rs_i == AW'(i)) ? rf_q[i] : opb;
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (accept ? EXEC : IDLE) : (state_q == EXEC) ? WB : IDLE;
    end
    always_comb begin
        ready = (state_q == IDLE) && Reset_n;
        done = (state_q == WB);
        accept = bus.InstValid && ready;
    end
    // Write-back owns the port in WB; preload only slips in on an idle cycle with no accept.
    always_comb begin
        wb_we = (state_q == WB) && (op_q != 3'd6);
        we = wb_we || (InitWe && (state_q == IDLE) && !accept);
        wa = wb_we ? rd_q : InitAddr;
        wd = wb_we ? ((op_q == 3'd7) ? datb_q : rslt_q) : InitData;
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) if (we && wa == AW'(i)) rf_q[i] <= wd;
        end
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            data_q <= '0;
            datb_q <= '0;
            op_q <= '0;
            rd_q <= '0;
            rslt_q <= '0;
            flh_q <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                data_q <= opa;
                datb_q <= opb;
                op_q <= op_i;
                rd_q <= rd_i;
            end
            if (state_q == EXEC) begin
                rslt_q <= bus.Rslt;
                flh_q <= {bus.SCo, bus.Par, bus.Zero};
            end
            if (state_q == WB && op_q != 3'd7) flags_q <= flh_q;
        end
    end
    assign bus.InstReady = ready;
    assign bus.Done = done;
    assign bus.DatA = data_q;
    assign bus.DatB = datb_q;
    assign bus.ALUop = op_q;
    assign bus.Flags = flags_q;
endmodule
